// File: rtl/reset_sequencer.sv
// Reset generator: asserts NUM_CH resets together, then releases them in channel
// order with per-channel gaps. Optional soft restart input under RST_SEQ_SOFT_EN.
module reset_sequencer #(
  parameter int                       NUM_CH     = 4,
  parameter int                       CNT_W      = 16,
  parameter logic [CNT_W-1:0]         INIT_HOLD  = 16'd8,
  parameter logic [NUM_CH*CNT_W-1:0]  DLY        = {16'd2, 16'd5, 16'd0, 16'd3},
  parameter logic [NUM_CH-1:0]        ACTIVE_LOW = 4'b0001
) (
  input  logic              FPGA_SYSCLK,
  input  logic              RESET,
  input  logic              ext_rst_req,
`ifdef RST_SEQ_SOFT_EN
  input  logic              soft_rst_req,
`endif
  output logic [NUM_CH-1:0] rst_out,
  output logic              seq_done,
  output logic [1:0]        seq_state
);

  localparam int               IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [CNT_W-1:0]   cur_dly;
  logic               release_now;
  logic [NUM_CH-1:0]  rst_nxt;
  logic               done_nxt;
  logic [1:0]         sync;
  logic               req;

  // Two-flop synchroniser for the asynchronous board-level request.
  always_ff @(posedge FPGA_SYSCLK) begin
    if (RESET) sync <= 2'b00;
    else       sync <= {sync[0], ext_rst_req};
  end

`ifdef RST_SEQ_SOFT_EN
  assign req = sync[1] | soft_rst_req;
`else
  assign req = sync[1];
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge FPGA_SYSCLK) begin
    if (RESET) begin
      state    <= ST_ASSERT;
      cnt      <= '0;
      idx      <= '0;
      rst_out  <= ~ACTIVE_LOW;
      seq_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      rst_out  <= rst_nxt;
      seq_done <= done_nxt;
    end
  end

  // Mux the current channel's gap out of the packed parameter without a
  // variable index, so non-power-of-two NUM_CH never selects out of range.
  always_comb begin
    cur_dly = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx == IDX_W'(k)) cur_dly = DLY[k*CNT_W +: CNT_W];
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    release_now = 1'b0;
    case (state)
      ST_ASSERT: begin
        if (req) begin
          cnt_nxt = '0;
        end else if (cnt == INIT_HOLD) begin
          state_nxt = ST_RELEASE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (req) begin
          state_nxt = ST_ASSERT;
          cnt_nxt   = '0;
        end else if (cnt == cur_dly) begin
          release_now = 1'b1;
          cnt_nxt     = '0;
          if (idx == LAST_IDX) state_nxt = ST_DONE;
          else                 idx_nxt   = idx + IDX_W'(1);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (req) begin
          state_nxt = ST_ASSERT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_ASSERT;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  // Next output values; registered alongside the state so no input reaches an
  // output combinationally.
  always_comb begin
    rst_nxt  = rst_out;
    done_nxt = 1'b0;
    case (state_nxt)
      ST_ASSERT: rst_nxt = ~ACTIVE_LOW;
      ST_DONE: begin
        rst_nxt  = ACTIVE_LOW;
        done_nxt = 1'b1;
      end
      default: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (release_now && idx == IDX_W'(k)) rst_nxt[k] = ACTIVE_LOW[k];
        end
      end
    endcase
  end

  assign seq_state = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default 4-channel instance plus a
// single-channel zero-delay instance. Define RST_SEQ_SOFT_EN to cover soft restart.
module tb_reset_sequencer;

  logic       clk;
  logic       RESET;
  logic       ext_rst_req;
  logic       ext1;
`ifdef RST_SEQ_SOFT_EN
  logic       soft_rst_req;
  logic       soft1;
`endif
  logic [3:0] rst_out;
  logic       seq_done;
  logic [1:0] seq_state;
  logic [0:0] rst1;
  logic       done1;
  logic [1:0] state1;

  int n_checks = 0;
  int n_errors = 0;

  // Hand-derived release edges (relative to E0) for the default instance:
  // DLY[0]=3, DLY[1]=0, DLY[2]=5, DLY[3]=2, INIT_HOLD=8.
  int         rel [4] = '{12, 13, 19, 22};
  logic [3:0] al      = 4'b0001;

  reset_sequencer u_dut (
    .FPGA_SYSCLK (clk),
    .RESET       (RESET),
    .ext_rst_req (ext_rst_req),
`ifdef RST_SEQ_SOFT_EN
    .soft_rst_req(soft_rst_req),
`endif
    .rst_out     (rst_out),
    .seq_done    (seq_done),
    .seq_state   (seq_state)
  );

  reset_sequencer #(
    .NUM_CH    (1),
    .CNT_W     (16),
    .INIT_HOLD (16'd0),
    .DLY       (16'd0),
    .ACTIVE_LOW(1'b0)
  ) u_dut1 (
    .FPGA_SYSCLK (clk),
    .RESET       (RESET),
    .ext_rst_req (ext1),
`ifdef RST_SEQ_SOFT_EN
    .soft_rst_req(soft1),
`endif
    .rst_out     (rst1),
    .seq_done    (done1),
    .seq_state   (state1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n edges starting at E0 and checks the default instance every edge.
  task automatic run_seq(input int n, input bit chk1);
    logic [3:0] exp_rst;
    for (int e = 0; e < n; e++) begin
      tick();
      for (int k = 0; k < 4; k++) exp_rst[k] = (e >= rel[k]) ? al[k] : ~al[k];
      check($sformatf("rst e%0d", e), rst_out, exp_rst);
      check($sformatf("state e%0d", e), seq_state, (e < 8) ? 2'd0 : (e < 22) ? 2'd1 : 2'd2);
      check($sformatf("done e%0d", e), seq_done, e >= 22);
      if (chk1) begin
        check($sformatf("rst1 e%0d", e), rst1, (e == 0) ? 1'b1 : 1'b0);
        check($sformatf("state1 e%0d", e), state1, (e == 0) ? 2'd1 : 2'd2);
        check($sformatf("done1 e%0d", e), done1, e >= 1);
      end
    end
  endtask

  initial begin
    RESET       = 1'b1;
    ext_rst_req = 1'b0;
    ext1        = 1'b0;
`ifdef RST_SEQ_SOFT_EN
    soft_rst_req = 1'b0;
    soft1        = 1'b0;
`endif
    repeat (5) tick();
    check("rst_rst", rst_out, 4'b1110);
    check("rst_done", seq_done, 1'b0);
    check("rst_state", seq_state, 2'd0);
    check("rst_cnt", u_dut.cnt, 16'd0);
    check("rst1_out", rst1, 1'b1);
    check("rst1_done", done1, 1'b0);

    // Full sequence from reset, including the single-channel instance.
    RESET = 1'b0;
    run_seq(23, 1'b1);

    // Single-cycle external request while channel 2 is pending.
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    run_seq(14, 1'b0);
    ext_rst_req = 1'b1;
    tick();
    ext_rst_req = 1'b0;
    check("pulse_e14_rst", rst_out, 4'b1101);
    check("pulse_e14_state", seq_state, 2'd1);
    tick();
    check("pulse_e15_rst", rst_out, 4'b1101);
    tick();
    check("pulse_e16_rst", rst_out, 4'b1110);
    check("pulse_e16_state", seq_state, 2'd0);
    check("pulse_e16_cnt", u_dut.cnt, 16'd0);
    run_seq(23, 1'b0);

    // Long external request from DONE.
    ext_rst_req = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (i <= 2) begin
        check($sformatf("hold%0d_rst", i), rst_out, 4'b0001);
        check($sformatf("hold%0d_state", i), seq_state, 2'd2);
      end else begin
        check($sformatf("hold%0d_rst", i), rst_out, 4'b1110);
        check($sformatf("hold%0d_state", i), seq_state, 2'd0);
        check($sformatf("hold%0d_cnt", i), u_dut.cnt, 16'd0);
      end
    end
    ext_rst_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("drop%0d_state", i), seq_state, 2'd0);
      check($sformatf("drop%0d_cnt", i), u_dut.cnt, 16'd0);
    end
    run_seq(23, 1'b0);

    // Block reset in the middle of RELEASE.
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    run_seq(15, 1'b0);
    RESET = 1'b1;
    tick();
    check("midrst_rst", rst_out, 4'b1110);
    check("midrst_done", seq_done, 1'b0);
    check("midrst_state", seq_state, 2'd0);
    check("midrst_cnt", u_dut.cnt, 16'd0);
    check("midrst_idx", u_dut.idx, 2'd0);
    RESET = 1'b0;
    run_seq(23, 1'b0);

`ifdef RST_SEQ_SOFT_EN
    // Soft restart pulse from DONE takes effect on the sampling edge.
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    check("soft_rst", rst_out, 4'b1110);
    check("soft_done", seq_done, 1'b0);
    check("soft_state", seq_state, 2'd0);
    run_seq(23, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
